// File: rtl/sram_serial_burst_ctrl.sv
// sram_serial_burst_ctrl: serial header/data in, burst write or burst read of an SRAM macro,
// read words streamed out LSB first on SO.
module sram_serial_burst_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  BGN,
    input  logic                  SI,
    input  logic                  LOAD_N,
    input  logic [DATA_WIDTH-1:0] PI,
    output logic                  RDY,
    output logic                  BUSY,
    output logic                  D_WE,
    output logic                  CEN,
    output logic                  SO,
    output logic                  SO_VLD,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] PO
);
    localparam int HDR_BITS = 1 + ADDR_WIDTH + LEN_WIDTH;
    localparam int CW = $clog2(HDR_BITS > DATA_WIDTH ? HDR_BITS : DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_WSHF, S_WR, S_RD, S_RCAP, S_RSHF, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [HDR_BITS-2:0]   r_hdr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_words;
    logic [HDR_BITS-1:0]   w_hdr_nxt;
    logic                  w_hdr_end, w_word_end, w_step;

    // The final header bit is taken straight from SI, so only HDR_BITS-1 bits need storing.
    assign w_hdr_nxt  = {SI, r_hdr};
    assign w_hdr_end  = r_cnt == CW'(HDR_BITS - 1);
    assign w_word_end = r_cnt == CW'(DATA_WIDTH - 1);
    assign w_step     = (r_state == S_WR || (r_state == S_RSHF && w_word_end)) && r_words != '0;

    always_ff @(posedge CLK or negedge BGN) begin
        if (!BGN)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = LOAD_N ? S_IDLE : S_HDR;
            S_HDR:   w_state_nxt = !w_hdr_end ? S_HDR : (w_hdr_nxt[0] ? S_WSHF : S_RD);
            S_WSHF:  w_state_nxt = w_word_end ? S_WR : S_WSHF;
            S_WR:    w_state_nxt = r_words == '0 ? S_DONE : S_WSHF;
            S_RD:    w_state_nxt = S_RCAP;
            S_RCAP:  w_state_nxt = S_RSHF;
            S_RSHF:  w_state_nxt = !w_word_end ? S_RSHF : (r_words == '0 ? S_DONE : S_RD);
            S_DONE:  w_state_nxt = LOAD_N ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        RDY    = r_state == S_DONE;
        BUSY   = r_state != S_IDLE && r_state != S_DONE;
        D_WE   = r_state == S_WR;
        CEN    = r_state == S_WR || r_state == S_RD;
        SO_VLD = r_state == S_RSHF;
        SO     = SO_VLD & r_data[0];
        A      = CEN ? r_addr : '0;
        PO     = D_WE ? r_data : '0;
    end

    always_ff @(posedge CLK or negedge BGN) begin
        if (!BGN) begin
            r_cnt   <= '0;
            r_hdr   <= '0;
            r_data  <= '0;
            r_addr  <= '0;
            r_words <= '0;
        end else begin
            r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + CW'(1);
            if (r_state == S_HDR)
                r_hdr <= w_hdr_nxt[HDR_BITS-1:1];
            if (r_state == S_HDR && w_hdr_end) begin
                r_addr  <= w_hdr_nxt[ADDR_WIDTH:1];
                r_words <= w_hdr_nxt[HDR_BITS-1 -: LEN_WIDTH];
            end else if (w_step) begin
                r_addr  <= r_addr + ADDR_WIDTH'(1);
                r_words <= r_words - LEN_WIDTH'(1);
            end
            if (r_state == S_WSHF)
                r_data <= {SI, r_data[DATA_WIDTH-1:1]};
            else if (r_state == S_RCAP)
                r_data <= PI;
            else if (r_state == S_RSHF)
                r_data <= r_data >> 1;
        end
    end
endmodule
